// File: rtl/dnn_pkg.sv
// Shared helpers for the DNN output stage: position widths, the most-negative
// activation constant and a signed compare used by the argmax logic.
package dnn_pkg;

   localparam int MAX_W = 64;
   localparam int LBL_SAT = 2;

   function automatic int pos_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic signed [MAX_W-1:0] most_neg(input int w);
      logic signed [MAX_W-1:0] r;
      r = '1;
      r = r << (w - 1);
      return r;
   endfunction

   function automatic logic sgt(input logic signed [MAX_W-1:0] a,
                                input logic signed [MAX_W-1:0] b);
      return a > b;
   endfunction

endpackage

// File: rtl/output_argmax_tracker_if.sv
// Activation/label stream in, per-block classification out.
// ACC_COUNTER_EN adds the running sample/correct counters and their clear.
interface output_argmax_tracker_if
   import dnn_pkg::*;
#(
   parameter int width = 10,
   parameter int N     = 1,
   parameter int P     = 4,
   parameter int cpc   = 6
`ifdef ACC_COUNTER_EN
   , parameter int cnt_width = 16
`endif
);
   localparam int POS_W = pos_w(P);
   localparam int CI_W  = pos_w(cpc);

   logic [CI_W-1:0]         cycle_index;
   logic                    cycle_clk;
   logic [width*N-1:0]      act_in;
   logic [N-1:0]            y_in;
   logic [P-1:0]            a_out_alln;
   logic [POS_W-1:0]        max_pos;
   logic signed [width-1:0] max_val;
   logic [POS_W-1:0]        y_pos;
   logic                    label_valid;
   logic                    correct;
   logic                    result_valid;
`ifdef ACC_COUNTER_EN
   logic                    clr_cnt;
   logic [cnt_width-1:0]    sample_cnt;
   logic [cnt_width-1:0]    correct_cnt;
`endif

   modport master (
`ifdef ACC_COUNTER_EN
      output clr_cnt, input sample_cnt, correct_cnt,
`endif
      output cycle_index, cycle_clk, act_in, y_in,
      input  a_out_alln, max_pos, max_val, y_pos, label_valid, correct, result_valid
   );

   modport slave (
`ifdef ACC_COUNTER_EN
      input clr_cnt, output sample_cnt, correct_cnt,
`endif
      input  cycle_index, cycle_clk, act_in, y_in,
      output a_out_alln, max_pos, max_val, y_pos, label_valid, correct, result_valid
   );

endinterface

// File: rtl/argmax_lane_reduce.sv
// Combinational signed max over N packed lanes; ties resolve to the lowest lane.
module argmax_lane_reduce
   import dnn_pkg::*;
#(
   parameter int width = 10,
   parameter int N     = 1
) (
   input  logic [width*N-1:0]    act_in,
   output logic signed [width-1:0] max_val,
   output logic [pos_w(N)-1:0]   max_lane
);
   localparam int LANE_W = pos_w(N);

   if (N == 1) begin : g_pass
      assign max_val  = act_in;
      assign max_lane = '0;
   end else begin : g_scan
      // Strict greater-than keeps the earliest lane on equal values.
      always_comb begin
         max_val  = act_in[width-1:0];
         max_lane = '0;
         for (int k = 1; k < N; k++) begin
            if (sgt(MAX_W'($signed(act_in[width*k +: width])), MAX_W'(max_val))) begin
               max_val  = act_in[width*k +: width];
               max_lane = LANE_W'(k);
            end
         end
      end
   end

endmodule

// File: rtl/output_argmax_tracker.sv
// Running argmax and ideal-label capture over each cycle block, committed on cycle_clk.
// Optional feature macro: ACC_COUNTER_EN (saturating sample/correct counters).
module output_argmax_tracker
   import dnn_pkg::*;
#(
   parameter int width     = 10,
   parameter int N         = 1,
   parameter int P         = 4,
   parameter int cpc       = 6,
   parameter int skip      = 2,
   parameter int cnt_width = 16
) (
   input logic                    clk,
   input logic                    reset,
   output_argmax_tracker_if.slave bus
);
   localparam int SLICES = P / N;
   localparam int POS_W  = pos_w(P);
   localparam int LANE_W = pos_w(N);
   localparam logic signed [MAX_W-1:0] MN_FULL = most_neg(width);
   localparam logic signed [width-1:0] MN      = MN_FULL[width-1:0];

   if (SLICES * N != P) begin : g_bad_ratio
      $error("output_argmax_tracker: P=%0d is not a multiple of N=%0d", P, N);
   end
   if (SLICES > cpc - skip) begin : g_bad_window
      $error("output_argmax_tracker: P/N=%0d slices do not fit in cpc-skip=%0d", SLICES, cpc - skip);
   end
   if (cnt_width < 1) begin : g_bad_cnt
      $error("output_argmax_tracker: cnt_width must be positive");
   end

   function automatic logic [1:0] sat_lbl(input logic [1:0] cnt, input int inc);
      return (int'(cnt) + inc >= LBL_SAT) ? 2'(LBL_SAT) : 2'(int'(cnt) + inc);
   endfunction

   logic signed [width-1:0] lane_max;
   logic [LANE_W-1:0]       lane_idx;
   logic                    vld_p0;
   logic [POS_W-1:0]        slice_base;
   logic [POS_W-1:0]        win_pos;
   logic [POS_W-1:0]        y_first_pos;
   logic                    y_any;
   logic [P-1:0]            onehot;
   logic                    correct_now;

   logic signed [width-1:0] acc_val_p1;
   logic [POS_W-1:0]        acc_pos_p1;
   logic [POS_W-1:0]        lbl_pos_p1;
   logic [1:0]              lbl_cnt_p1;
   logic                    primed;

   argmax_lane_reduce #(.width(width), .N(N)) u_reduce (
      .act_in   (bus.act_in),
      .max_val  (lane_max),
      .max_lane (lane_idx)
   );

   // Stage p0: slice qualification and global positions of the lane winner / first label bit
   always_comb begin
      int y_lane;
      vld_p0 = !bus.cycle_clk && (int'(bus.cycle_index) >= skip) &&
               (int'(bus.cycle_index) < skip + SLICES);
      slice_base = POS_W'((int'(bus.cycle_index) - skip) * N);
      win_pos    = slice_base + POS_W'(lane_idx);
      y_any      = |bus.y_in;
      y_lane     = 0;
      for (int k = N - 1; k >= 0; k--) begin
         if (bus.y_in[k]) y_lane = k;
      end
      y_first_pos = slice_base + POS_W'(y_lane);
      onehot = '0;
      onehot[acc_pos_p1] = 1'b1;
      correct_now = (lbl_cnt_p1 == 2'd1) && (lbl_pos_p1 == acc_pos_p1);
   end

   // Stage p1: block accumulators; commit and reinitialise on cycle_clk
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_val_p1       <= MN;
         acc_pos_p1       <= '0;
         lbl_pos_p1       <= '0;
         lbl_cnt_p1       <= '0;
         primed           <= 1'b0;
         bus.a_out_alln   <= '0;
         bus.max_pos      <= '0;
         bus.max_val      <= '0;
         bus.y_pos        <= '0;
         bus.label_valid  <= 1'b0;
         bus.correct      <= 1'b0;
         bus.result_valid <= 1'b0;
      end else begin
         bus.result_valid <= 1'b0;
         if (bus.cycle_clk) begin
            bus.max_val      <= acc_val_p1;
            bus.max_pos      <= acc_pos_p1;
            bus.a_out_alln   <= onehot;
            bus.y_pos        <= lbl_pos_p1;
            bus.label_valid  <= (lbl_cnt_p1 == 2'd1);
            bus.correct      <= correct_now;
            // The first boundary after reset closes a partial block.
            bus.result_valid <= primed;
            primed           <= 1'b1;
            acc_val_p1       <= MN;
            acc_pos_p1       <= '0;
            lbl_pos_p1       <= '0;
            lbl_cnt_p1       <= '0;
         end else if (vld_p0) begin
            if (sgt(MAX_W'(lane_max), MAX_W'(acc_val_p1))) begin
               acc_val_p1 <= lane_max;
               acc_pos_p1 <= win_pos;
            end
            if (lbl_cnt_p1 == 2'd0 && y_any) lbl_pos_p1 <= y_first_pos;
            lbl_cnt_p1 <= sat_lbl(lbl_cnt_p1, $countones(bus.y_in));
         end
      end
   end

`ifdef ACC_COUNTER_EN
   function automatic logic [cnt_width-1:0] sat_inc(input logic [cnt_width-1:0] c, input logic en);
      return (en && !(&c)) ? c + 1'b1 : c;
   endfunction

   always_ff @(posedge clk) begin
      if (reset || bus.clr_cnt) begin
         bus.sample_cnt  <= '0;
         bus.correct_cnt <= '0;
      end else if (bus.cycle_clk && primed) begin
         bus.sample_cnt  <= sat_inc(bus.sample_cnt, 1'b1);
         bus.correct_cnt <= sat_inc(bus.correct_cnt, correct_now);
      end
   end
`endif

endmodule

// File: tb/tb_output_argmax_tracker.sv
// Scoreboard bench: one N=1/P=4 tracker and one N=2/P=8 tracker fed block-aligned streams.
module tb_output_argmax_tracker;
   import dnn_pkg::*;

   typedef struct {
      int pos;
      int val;
      int ypos;
      bit lv;
      bit cor;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

`ifdef ACC_COUNTER_EN
   output_argmax_tracker_if #(.width(10), .N(1), .P(4), .cpc(6), .cnt_width(16)) bus_a ();
   output_argmax_tracker_if #(.width(10), .N(2), .P(8), .cpc(6), .cnt_width(2))  bus_b ();
`else
   output_argmax_tracker_if #(.width(10), .N(1), .P(4), .cpc(6)) bus_a ();
   output_argmax_tracker_if #(.width(10), .N(2), .P(8), .cpc(6)) bus_b ();
`endif

   output_argmax_tracker #(.width(10), .N(1), .P(4), .cpc(6), .skip(2), .cnt_width(16)) u_dut_a (
      .clk(clk), .reset(reset), .bus(bus_a));
   output_argmax_tracker #(.width(10), .N(2), .P(8), .cpc(6), .skip(2), .cnt_width(2)) u_dut_b (
      .clk(clk), .reset(reset), .bus(bus_b));

   int   n_vec = 0;
   int   n_err = 0;
   exp_t q_a[$];
   exp_t q_b[$];
   int   cur_a[8];
   int   cur_b[8];
   logic [7:0] y_a;
   logic [7:0] y_b;
   exp_t pend_a, pend_b;
   bit   pend_ok  = 1'b0;
   bit   primed_m = 1'b0;
   bit   mon_en   = 1'b0;
   int   smp_a = 0, cor_a = 0, smp_b = 0, cor_b = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input int acts[8], input logic [7:0] y, input int p);
      exp_t e;
      int   best = -512;
      int   cnt  = 0;
      e.pos  = 0;
      e.ypos = 0;
      for (int i = 0; i < p; i++) begin
         if (acts[i] > best) begin
            best  = acts[i];
            e.pos = i;
         end
         if (y[i]) begin
            if (cnt == 0) e.ypos = i;
            cnt++;
         end
      end
      e.val = best;
      e.lv  = (cnt == 1);
      e.cor = e.lv && (e.ypos == e.pos);
      return e;
   endfunction

   task automatic cmp_out(input string who, input exp_t e, input logic [63:0] oh,
                          input logic [63:0] pos, input logic [63:0] val, input logic [63:0] ypos,
                          input logic [63:0] lv, input logic [63:0] cor);
      check({who, "_max_pos"}, pos, 64'(e.pos));
      check({who, "_max_val"}, val, 64'(e.val));
      check({who, "_onehot"}, oh, 64'(1) << e.pos);
      check({who, "_y_pos"}, ypos, 64'(e.ypos));
      check({who, "_label_valid"}, lv, 64'(e.lv));
      check({who, "_correct"}, cor, 64'(e.cor));
   endtask

   always @(negedge clk) begin
      exp_t ea, eb;
      if (mon_en && !reset) begin
         if (bus_a.result_valid !== 1'b0) begin
            if (q_a.size() == 0) check("a_unexpected_valid", 64'(bus_a.result_valid), 64'd0);
            else begin
               ea = q_a.pop_front();
               cmp_out("a", ea, 64'(bus_a.a_out_alln), 64'(bus_a.max_pos), 64'(bus_a.max_val),
                       64'(bus_a.y_pos), 64'(bus_a.label_valid), 64'(bus_a.correct));
            end
         end
         if (bus_b.result_valid !== 1'b0) begin
            if (q_b.size() == 0) check("b_unexpected_valid", 64'(bus_b.result_valid), 64'd0);
            else begin
               eb = q_b.pop_front();
               cmp_out("b", eb, 64'(bus_b.a_out_alln), 64'(bus_b.max_pos), 64'(bus_b.max_val),
                       64'(bus_b.y_pos), 64'(bus_b.label_valid), 64'(bus_b.correct));
            end
         end
      end
   end

   task automatic check_cleared(input string who);
      if (who == "a") begin
         check("a_cleared_outputs", {bus_a.a_out_alln, bus_a.max_pos, bus_a.max_val,
               bus_a.y_pos, bus_a.label_valid, bus_a.correct}, 64'd0);
         check("a_cleared_valid", 64'(bus_a.result_valid), 64'd0);
      end else begin
         check("b_cleared_outputs", {bus_b.a_out_alln, bus_b.max_pos, bus_b.max_val,
               bus_b.y_pos, bus_b.label_valid, bus_b.correct}, 64'd0);
         check("b_cleared_valid", 64'(bus_b.result_valid), 64'd0);
      end
   endtask

   // One cpc=6 block: index 0 carries cycle_clk, 1 is garbage, 2..5 carry slices.
   task automatic run_block(input int rst_at, input bit clr);
      for (int c = 0; c < 6; c++) begin
         @(posedge clk);
         #1;
         if (reset) begin
            reset = 1'b0;
            check_cleared("a");
            check_cleared("b");
         end
         bus_a.cycle_index = 3'(c);
         bus_b.cycle_index = 3'(c);
         bus_a.cycle_clk   = (c == 0);
         bus_b.cycle_clk   = (c == 0);
`ifdef ACC_COUNTER_EN
         bus_a.clr_cnt = (c == 0) && clr;
         bus_b.clr_cnt = (c == 0) && clr;
`endif
         if (c == 0) begin
            if (primed_m && pend_ok) begin
               q_a.push_back(pend_a);
               q_b.push_back(pend_b);
               smp_a++; smp_b++;
               if (pend_a.cor) cor_a++;
               if (pend_b.cor) cor_b++;
            end
            if (clr) begin
               smp_a = 0; cor_a = 0; smp_b = 0; cor_b = 0;
            end
            primed_m = 1'b1;
            pend_ok  = 1'b0;
         end
         if (c >= 2) begin
            bus_a.act_in = 10'(cur_a[c-2]);
            bus_a.y_in   = y_a[c-2];
            bus_b.act_in = {10'(cur_b[2*(c-2)+1]), 10'(cur_b[2*(c-2)])};
            bus_b.y_in   = {y_b[2*(c-2)+1], y_b[2*(c-2)]};
         end else begin
            bus_a.act_in = 10'($urandom);
            bus_a.y_in   = 1'($urandom);
            bus_b.act_in = 20'($urandom);
            bus_b.y_in   = 2'($urandom);
         end
         if (c == rst_at) begin
            reset    = 1'b1;
            primed_m = 1'b0;
            smp_a = 0; cor_a = 0; smp_b = 0; cor_b = 0;
         end
      end
      pend_a  = model(cur_a, y_a, 4);
      pend_b  = model(cur_b, y_b, 8);
      pend_ok = 1'b1;
   endtask

   task automatic rand_data(input int mode);
      for (int i = 0; i < 8; i++) begin
         cur_a[i] = int'($urandom_range(0, 1023)) - 512;
         cur_b[i] = int'($urandom_range(0, 1023)) - 512;
      end
      case (mode)
         0: begin y_a = 8'(1 << $urandom_range(0, 3)); y_b = 8'(1 << $urandom_range(0, 7)); end
         1: begin y_a = '0; y_b = '0; end
         2: begin y_a = 8'($urandom); y_b = 8'($urandom); end
         default: begin
            y_a = 8'(1 << model(cur_a, 8'd0, 4).pos);
            y_b = 8'(1 << model(cur_b, 8'd0, 8).pos);
         end
      endcase
   endtask

   initial begin
      reset = 1'b1;
      bus_a.cycle_index = '0; bus_a.cycle_clk = 1'b0; bus_a.act_in = '0; bus_a.y_in = '0;
      bus_b.cycle_index = '0; bus_b.cycle_clk = 1'b0; bus_b.act_in = '0; bus_b.y_in = '0;
`ifdef ACC_COUNTER_EN
      bus_a.clr_cnt = 1'b0;
      bus_b.clr_cnt = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check_cleared("a");
      check_cleared("b");
      mon_en = 1'b1;

      cur_a = '{3, -7, 12, 5, 0, 0, 0, 0};          y_a = 8'b0000_0100;
      cur_b = '{1, 2, 3, 4, 5, 6, 7, 100};          y_b = 8'b0100_0000;
      run_block(-1, 1'b0);
      cur_a = '{9, 9, -1, 9, 0, 0, 0, 0};           y_a = 8'b0000_0001;
      cur_b = '{4, 4, 4, 4, 4, 4, 4, 4};            y_b = 8'b0000_0001;
      run_block(-1, 1'b0);
      cur_a = '{-512, -512, -512, -512, 0, 0, 0, 0}; y_a = 8'b0000_0000;
      cur_b = '{-512, -512, -512, -512, -512, -512, -512, -512}; y_b = 8'b0011_0000;
      run_block(-1, 1'b0);
      rand_data(3);
      run_block(3, 1'b0);
      rand_data(3);
      run_block(-1, 1'b0);
      for (int b = 0; b < 6; b++) begin
         rand_data(b % 4);
         run_block(-1, b == 0);
      end
      rand_data(2);
      run_block(-1, 1'b0);

      @(posedge clk);
      #1;
      bus_a.cycle_clk = 1'b0; bus_a.cycle_index = '0;
      bus_b.cycle_clk = 1'b0; bus_b.cycle_index = '0;
      repeat (4) @(posedge clk);
      #1;
      check("a_pending_results", 64'(q_a.size()), 64'd0);
      check("b_pending_results", 64'(q_b.size()), 64'd0);
`ifdef ACC_COUNTER_EN
      check("a_sample_cnt", 64'(bus_a.sample_cnt), 64'((smp_a > 65535) ? 65535 : smp_a));
      check("a_correct_cnt", 64'(bus_a.correct_cnt), 64'((cor_a > 65535) ? 65535 : cor_a));
      check("b_sample_cnt", 64'(bus_b.sample_cnt), 64'((smp_b > 3) ? 3 : smp_b));
      check("b_correct_cnt", 64'(bus_b.correct_cnt), 64'((cor_b > 3) ? 3 : cor_b));
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
